latch_capture_reg: RTL and testbench
====================================

LATCH_CAPTURE_REG -- requirements
Module: latch_capture_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width of the latch word being captured.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on latch_en; legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 latch_en  input  1  level-sensitive enable of the upstream latch stage; high = latch transparent, low = latch holding.
REQ-006 latch_q  input  WIDTH  upstream latch output.
REQ-007 out_ready  input  1  downstream accepts out_data when high.
REQ-008 out_valid  output  1  out_data holds a captured word.
REQ-009 out_data  output  WIDTH  oldest captured word.
REQ-010 overflow  output  1  sticky flag: a capture was dropped because the buffer was full.
REQ-011 capture_count  output  8  number of captures accepted into the buffer, modulo 256.

Function
REQ-012 latch_en shall pass through a SYNC_STAGES-deep flop chain (s[0]..s[S-1]) followed by a one-flop history register en_prev.
REQ-013 Capture event: cap = en_prev & ~s[S-1], i.e. the synchronized falling edge (latch closing); rising edges and steady levels shall produce no capture.
REQ-014 On a posedge where cap is high, latch_q shall be sampled directly, unsynchronized; the upstream stage holds latch_q stable while latch_en is low for at least SYNC_STAGES+1 cycles.
REQ-015 Latency: if latch_en is first sampled low at posedge t, the word shall be written at posedge t+SYNC_STAGES, and out_valid shall be high after that edge when the buffer was empty.
REQ-016 Captured words shall enter a 2-entry FIFO, with states EMPTY, ONE and FULL; out_data shall be the head entry, and out_valid = (state != EMPTY).
REQ-017 Pop occurs on a posedge with out_valid & out_ready; out_data and out_valid shall stay stable while out_valid & ~out_ready.
REQ-018 State transitions: EMPTY -push-> ONE. ONE -push only-> FULL. ONE -pop only-> EMPTY. ONE -push+pop-> ONE, with the new word at the head. FULL -pop-> ONE. FULL -push+pop-> FULL, with the second entry moving to the head and the new word at the tail.
REQ-019 Push into FULL without a simultaneous pop shall drop the word, leave FIFO contents unchanged, set overflow=1 and leave capture_count unchanged.
REQ-020 overflow shall remain 1 until rst.
REQ-021 capture_count shall increment by 1 on every accepted push, wrapping 255->0.
REQ-022 FIFO order shall be strictly first-in-first-out; no word shall be duplicated or reordered.
REQ-023 out_data shall equal 0 when the FIFO is EMPTY.

Reset
REQ-024 While rst is high at a posedge, the following shall clear: s[0..S-1]=0, en_prev=0, FIFO=EMPTY, out_data=0, out_valid=0, overflow=0, capture_count=0.
REQ-025 Because the chain resets to 0, latch_en held high through and after reset shall produce no capture until it falls.
REQ-026 Reset asserted mid-operation shall discard buffered words and any in-flight capture in the synchronizer; out_valid shall be 0 on the first cycle after the reset edge.
REQ-027 rst shall take priority over cap, push and pop on the same edge.

Verification
REQ-028 WIDTH=8, SYNC_STAGES=2, out_ready=1: latch_en 1->0 at edge t with latch_q=0xA5 -> out_valid=1 and out_data=0xA5 after edge t+2, out_valid=0 after edge t+3, capture_count=1.
REQ-029 out_ready=0; three falling edges carrying 0x11, 0x22, 0x33 -> FIFO FULL holding 0x11,0x22; overflow=1; capture_count=2; with out_ready=1 afterwards, 0x11 then 0x22 are delivered and out_valid falls.
REQ-030 FIFO FULL with 0x11,0x22; push of 0x33 on the same edge as a pop -> no overflow; next words delivered are 0x22 then 0x33; capture_count increments.
REQ-031 latch_en held high across rst deassertion, then toggled 0->1 -> no capture, out_valid stays 0; the subsequent 1->0 produces exactly one capture.
REQ-032 256 captures with out_ready=1 -> capture_count wraps to 0; overflow stays 0.
REQ-033 rst pulsed while FIFO is ONE and a falling edge is in the synchronizer -> after reset, out_valid=0, capture_count=0, and no word from before the reset appears.

Source files
------------

// File: rtl/latch_capture_reg.sv
// ---------------------------------------------------------------------------
// latch_capture_reg : captures a level-latch word on the synchronized falling
// edge of its enable and buffers it in a 2-entry FIFO.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module latch_capture_reg #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_en,
  input  logic [WIDTH-1:0] latch_q,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic [7:0]       capture_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   en_prev;
  logic                   cap;
  logic                   pop;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       head, head_nxt;
  logic [WIDTH-1:0]       tail, tail_nxt;
  logic                   accept;
  logic                   drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      en_prev <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], latch_en};
      en_prev <= sync[SYNC_STAGES-1];
    end
  end

  // latch_q is sampled raw: the upstream latch is already holding by now
  assign cap       = en_prev & ~sync[SYNC_STAGES-1];
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (cap) begin
          state_nxt = ONE;
          head_nxt  = latch_q;
          accept    = 1'b1;
        end
      end
      ONE: begin
        case ({cap, pop})
          2'b11: begin
            head_nxt = latch_q;
            accept   = 1'b1;
          end
          2'b10: begin
            state_nxt = FULL;
            tail_nxt  = latch_q;
            accept    = 1'b1;
          end
          2'b01: begin
            state_nxt = EMPTY;
            head_nxt  = '0;
          end
          default: ;
        endcase
      end
      FULL: begin
        case ({cap, pop})
          2'b11: begin
            head_nxt = tail;
            tail_nxt = latch_q;
            accept   = 1'b1;
          end
          2'b10: drop = 1'b1;
          2'b01: begin
            state_nxt = ONE;
            head_nxt  = tail;
            tail_nxt  = '0;
          end
          default: ;
        endcase
      end
      default: begin
        state_nxt = EMPTY;
        head_nxt  = '0;
        tail_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      head          <= '0;
      tail          <= '0;
      overflow      <= 1'b0;
      capture_count <= 8'd0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        capture_count <= capture_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_capture_reg.sv
// ---------------------------------------------------------------------------
// tb_latch_capture_reg : directed and random checks against a queue model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_latch_capture_reg;
  localparam int WIDTH = 8;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             latch_en;
  logic [WIDTH-1:0] latch_q;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             overflow;
  logic [7:0]       capture_count;

  latch_capture_reg #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .latch_en(latch_en), .latch_q(latch_q),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .overflow(overflow), .capture_count(capture_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: hist[0] is latch_en as seen at the previous edge, hist[i] i edges earlier
  bit               hist[$];
  logic [WIDTH-1:0] mq[$];
  int               m_count;
  bit               m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    mq.delete();
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit cap;
    bit pop;
    if (rst) begin
      model_reset();
      return;
    end
    // closing seen S edges ago, open the edge before that
    cap = hist[S] && !hist[S-1];
    pop = (mq.size() > 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < 2) begin
        mq.push_back(latch_q);
        m_count = (m_count + 1) % 256;
      end else begin
        m_ovf = 1'b1;
      end
    end
    hist.push_front(latch_en);
    void'(hist.pop_back());
  endtask

  task automatic cycle();
    logic [WIDTH-1:0] exp_data;
    @(posedge clk);
    model_edge();
    #1;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("out_data", {24'd0, out_data}, {24'd0, exp_data});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("capture_count", {24'd0, capture_count}, m_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // One latch open/close with the word held stable while closed
  task automatic fall(input logic [WIDTH-1:0] data);
    latch_en = 1'b1;
    latch_q  = data;
    cycle();
    cycle();
    latch_en = 1'b0;
    for (int i = 0; i <= S; i++) cycle();
  endtask

  initial begin
    int phase_left;
    rst       = 1'b1;
    latch_en  = 1'b0;
    latch_q   = '0;
    out_ready = 1'b1;
    model_reset();
    do_reset();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_count", {24'd0, capture_count}, 32'd0);

    // single capture latency with ready high
    latch_en = 1'b1;
    cycle();
    cycle();
    latch_q  = 8'hA5;
    latch_en = 1'b0;
    cycle();
    cycle();
    check("lat_early", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", {24'd0, out_data}, 32'h0000_00A5);
    cycle();
    check("lat_pop", {31'd0, out_valid}, 32'd0);
    check("lat_count", {24'd0, capture_count}, 32'd1);

    // overflow on third capture
    do_reset();
    out_ready = 1'b0;
    fall(8'h11);
    fall(8'h22);
    fall(8'h33);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", {24'd0, capture_count}, 32'd2);
    check("ovf_head", {24'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    cycle();
    check("ovf_second", {24'd0, out_data}, 32'h22);
    cycle();
    check("ovf_drain", {31'd0, out_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // push into FULL on the same edge as a pop
    do_reset();
    out_ready = 1'b0;
    fall(8'h11);
    fall(8'h22);
    latch_en = 1'b1;
    cycle();
    cycle();
    latch_q  = 8'h33;
    latch_en = 1'b0;
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    check("pp_head", {24'd0, out_data}, 32'h22);
    check("pp_noovf", {31'd0, overflow}, 32'd0);
    check("pp_count", {24'd0, capture_count}, 32'd3);
    cycle();
    check("pp_tail", {24'd0, out_data}, 32'h33);
    cycle();
    check("pp_empty", {31'd0, out_valid}, 32'd0);

    // enable held high through reset release
    latch_en  = 1'b1;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    check("hi_rst_valid", {31'd0, out_valid}, 32'd0);
    check("hi_rst_count", {24'd0, capture_count}, 32'd0);
    latch_q  = 8'h6C;
    latch_en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    latch_en = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("hi_rst_one", {24'd0, capture_count}, 32'd1);
    check("hi_rst_data", {24'd0, out_data}, 32'h6C);

    // count wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) fall(WIDTH'($urandom));
    check("wrap_count", {24'd0, capture_count}, 32'd0);
    check("wrap_ovf", {31'd0, overflow}, 32'd0);

    // reset while a word is buffered and another is in the synchronizer
    do_reset();
    out_ready = 1'b0;
    fall(8'h5A);
    latch_en = 1'b1;
    cycle();
    cycle();
    latch_q  = 8'hC3;
    latch_en = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {24'd0, capture_count}, 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);

    // random traffic
    phase_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (phase_left == 0) begin
        latch_en = ~latch_en;
        if (latch_en) begin
          latch_q    = WIDTH'($urandom);
          phase_left = $urandom_range(1, 4);
        end else begin
          phase_left = $urandom_range(S + 1, 6);
        end
      end
      phase_left--;
      out_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
